// File: rtl/tick_sched_pkg.sv
// Shared constants, channel-index width helper and FSM state type for the tick scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tick_sched_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  // Channel index width; never below one bit so a 2-channel build still has a select.
  function automatic int calc_ch_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/tick_rr_arbiter.sv
// Round-robin pick of one pending channel, searching upward from last_grant+1 with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module tick_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic              any,
  output logic [CH_W-1:0]   grant
);

  logic [CH_W-1:0] idx;

  // Walk channels in rotated order; the first requester found wins.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((int'(last_grant) + i) % NUM_CH);
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Per-channel periodic expiry counters feeding a round-robin valid/ready fire port.
// Latency: expiry on tick at cycle t -> pending at t+1 -> fire_valid at t+2 when idle.
// Backpressure: offer held stable until fire_ready; repeat expiries flagged in overrun
// (overrun tracking present only when TICK_SCHED_OVERRUN_EN is defined).
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int  NUM_CH = NUM_CH_DEF,
  parameter int  CNT_W  = CNT_W_DEF,
  localparam int CH_W   = calc_ch_w(NUM_CH)
) (
  input  logic              inclk,
  input  logic              rst,
  input  logic              tick_in,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  output logic              fire_valid,
  output logic [CH_W-1:0]   fire_ch,
  input  logic              fire_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun,
  input  logic [NUM_CH-1:0] overrun_clr
);

  logic [CNT_W-1:0]  period_q  [NUM_CH];
  logic [CNT_W-1:0]  counter_q [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] cfg_hit, expire, hs_clr;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   fire_ch_q, fire_ch_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic              arb_any;
  logic [CH_W-1:0]   arb_grant;
  logic              handshake;

  assign handshake  = (state_q == OFFER) && fire_ready;
  assign fire_valid = (state_q == OFFER);
  assign fire_ch    = fire_ch_q;
  assign pending    = pending_q;

  // Per-channel event decode: config hits mask same-cycle ticks; a new expiry beats the handshake clear.
  always_comb begin
    cfg_hit   = '0;
    expire    = '0;
    hs_clr    = '0;
    pending_d = pending_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
      expire[i]  = tick_in && !cfg_hit[i] && (period_q[i] != '0) && (counter_q[i] == CNT_W'(1));
      hs_clr[i]  = handshake && (fire_ch_q == CH_W'(i));
      if (cfg_hit[i])
        pending_d[i] = 1'b0;
      else if (expire[i])
        pending_d[i] = 1'b1;
      else if (hs_clr[i])
        pending_d[i] = 1'b0;
    end
  end

  // Period registers and down-counters; reload at 1 so the counter never wraps.
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period_q[i]  <= '0;
        counter_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_hit[i]) begin
          period_q[i]  <= cfg_period;
          counter_q[i] <= cfg_period;
        end else if (tick_in && (period_q[i] != '0)) begin
          if (counter_q[i] > CNT_W'(1))
            counter_q[i] <= counter_q[i] - CNT_W'(1);
          else if (counter_q[i] == CNT_W'(1))
            counter_q[i] <= period_q[i];
        end
      end
    end
  end

  // Pending request flags.
  always_ff @(posedge inclk or posedge rst) begin
    if (rst)
      pending_q <= '0;
    else
      pending_q <= pending_d;
  end

`ifdef TICK_SCHED_OVERRUN_EN
  logic [NUM_CH-1:0] overrun_q;
  logic [NUM_CH-1:0] overrun_set;

  // An expiry landing on a still-pending channel is lost, unless that request is being accepted right now.
  assign overrun_set = expire & pending_q & ~hs_clr;
  assign overrun     = overrun_q;

  // Sticky lost-expiry flags; a same-cycle set beats the write-1-to-clear.
  always_ff @(posedge inclk or posedge rst) begin
    if (rst)
      overrun_q <= '0;
    else
      overrun_q <= (overrun_q & ~overrun_clr) | overrun_set;
  end
`else
  logic unused_overrun_clr;

  assign unused_overrun_clr = ^overrun_clr;
  assign overrun            = '0;
`endif

  tick_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req        (pending_q),
    .last_grant (last_grant_q),
    .any        (arb_any),
    .grant      (arb_grant)
  );

  // Offer FSM state, latched channel and round-robin pointer.
  always_ff @(posedge inclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fire_ch_q    <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
    end else begin
      state_q      <= state_d;
      fire_ch_q    <= fire_ch_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state: latch a grant when idle, hold it until the consumer accepts.
  always_comb begin
    state_d      = state_q;
    fire_ch_d    = fire_ch_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d   = OFFER;
          fire_ch_d = arb_grant;
        end
      end
      OFFER: begin
        if (fire_ready) begin
          state_d      = IDLE;
          last_grant_d = fire_ch_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Multi-channel periodic event scheduler driven by the one-cycle base tick from the system clock divider. Each channel has a programmable period, counted in base ticks, and raises a pending request when its period expires. A round-robin arbiter serialises the pending requests onto a single valid/ready fire port, which consumers use to sequence time-sliced work off one divider. Lost expiries are flagged per channel.

## Interface
Parameters:
- NUM_CH, 4, number of channels (2..8)
- CNT_W, 8, period/counter width in base ticks

Ports:
- inclk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- tick_in  in  1  base tick strobe from divider; one inclk cycle wide
- cfg_we  in  1  config write strobe
- cfg_ch  in  CH_W  channel index for write (CH_W = clog2(NUM_CH))
- cfg_period  in  CNT_W  period in ticks; 0 = channel disabled
- fire_valid  out  1  expiry event offered
- fire_ch  out  CH_W  channel of offered event
- fire_ready  in  1  consumer accepts event
- pending  out  NUM_CH  per-channel pending flags
- overrun  out  NUM_CH  sticky lost-expiry flags
- overrun_clr  in  NUM_CH  write-1-to-clear for overrun

## Operation
- Reset values: all periods 0, counters 0, pending 0, overrun 0, fire_valid 0, fire_ch 0, last grant = NUM_CH-1 (first search starts at ch0).
- Counter per channel, loaded with period. On tick_in with period != 0:
  - counter > 1: decrement.
  - counter == 1: reload with period and set pending (expiry).
- Result: one expiry every P ticks.
- Period 1 expires on every tick. Period 0 holds the counter at 0 and never expires.
- cfg_we: period[cfg_ch] and counter[cfg_ch] <- cfg_period; pending[cfg_ch] cleared. Takes priority over a same-cycle tick for that channel.
- Expiry while pending already set: pending stays 1, overrun bit set (sticky).
- FSM states:
  - IDLE: if pending != 0, go to OFFER. Latch fire_ch = first set bit searching from last_grant+1 with wrap; fire_valid <= 1.
  - OFFER: hold fire_valid and fire_ch stable until fire_ready. On handshake: clear pending[fire_ch], last_grant <= fire_ch, fire_valid <= 0, return to IDLE.
- Handshake-clear and a new expiry of the same channel in the same cycle: the set wins, with no overrun. The new event is a fresh request.
- cfg_we to the offered channel during OFFER: the offer completes normally. The handshake clear is harmless.
- overrun_clr and a new overrun in the same cycle: set wins.

## Timing
- Expiry on tick at cycle t: pending visible at t+1; fire_valid at t+2 if FSM idle.
- Minimum 2 cycles per event: 1 OFFER cycle + 1 IDLE cycle. Max throughput one event per 2 inclk cycles.
- fire_valid never deasserts without fire_ready once asserted, except on rst.
- rst mid-OFFER: offer dropped and all state returned to reset values immediately (asynchronous).
- Counter arithmetic unsigned, CNT_W bits; no wrap possible since reload occurs at 1.

## Configuration
- TICK_SCHED_OVERRUN_EN defined: overrun tracking and overrun_clr as above.
- TICK_SCHED_OVERRUN_EN undefined: overrun logic removed, overrun output driven to 0, overrun_clr ignored. Port list unchanged.

## Structure
- Shared package tick_sched_pkg:
  - constants NUM_CH_DEF, CNT_W_DEF
  - function computing CH_W
  - FSM state typedef (IDLE, OFFER)
- Sub-module tick_rr_arbiter: combinational round-robin select (pending, last_grant -> any, grant index). Channel counters and FSM stay in the top.

## Test plan
- Single channel: period[0]=3, tick every 10 cycles -> fire_ch=0 offered after ticks 3, 6, 9; fire_valid rises 2 cycles after each expiring tick; fire_ready held 1.
- Fairness: ch0..ch3 period 1, fire_ready=1 -> fire_ch sequence 0,1,2,3,0,1... with no channel repeated before all pending ones are served.
- Backpressure and overrun: period[2]=1, fire_ready=0 for 3 ticks -> fire_valid/fire_ch=2 held stable, overrun[2]=1. overrun_clr[2] clears it; without TICK_SCHED_OVERRUN_EN, overrun stays 0.
- Reconfigure: write period[1]=5 while counter[1]=2 and pending[1]=1 -> pending[1]=0, next expiry after 5 further ticks; period 0 write -> no further expiries.
- Simultaneous: ch1 expires in the same cycle its offer handshakes -> pending[1] stays 1, no overrun, ch1 re-offered after the other pending channels in round-robin order.
- Reset mid-OFFER: assert rst while fire_valid=1 -> fire_valid, pending, overrun, fire_ch all 0 immediately; periods return to 0.
